// File: rtl/argmax_4_16_if.sv
// ---------------------------------------------------------------------------
// argmax_4_16_if : stream bundle between a score producer and the argmax head.
//
// Handshake: on each side a word moves on a rising clock edge exactly when
// valid && ready are both high on that edge. A sender holds valid and data
// steady until that transfer happens. A receiver may raise or drop ready at
// any time.
//
// Parameters
//   T  : score element width (two's-complement signed)
//   IW : index width
//
// Signals
//   input_valid / input_ready / input_data    : score element stream (0..M-1)
//   output_valid / output_ready / output_data : argmax index stream
//   output_max                                : winning score
//                                               (only with ARGMAX_MAXVAL_EN)
//
// Modports
//   master : the environment (drives scores, consumes indices)
//   slave  : the argmax block
// ---------------------------------------------------------------------------
interface argmax_4_16_if #(
  parameter int T  = 16,
  parameter int IW = 2
);
  logic          input_valid;
  logic          input_ready;
  logic [T-1:0]  input_data;
  logic          output_valid;
  logic          output_ready;
  logic [IW-1:0] output_data;
`ifdef ARGMAX_MAXVAL_EN
  logic [T-1:0]  output_max;
`endif

  modport master (
    output input_valid, input_data, output_ready,
    input  input_ready, output_valid, output_data
`ifdef ARGMAX_MAXVAL_EN
    , input output_max
`endif
  );

  modport slave (
    input  input_valid, input_data, output_ready,
    output input_ready, output_valid, output_data
`ifdef ARGMAX_MAXVAL_EN
    , output output_max
`endif
  );
endinterface

// File: rtl/argmax_4_16.sv
// ---------------------------------------------------------------------------
// argmax_4_16 : classifier head. Collects M signed T-bit scores per vector and
// emits the index of the largest one. Ties keep the lower index. One result
// is buffered, so the next vector can be scanned while that result waits on
// downstream.
//
// Optional feature (macro ARGMAX_MAXVAL_EN): also outputs the winning score on
// bus.output_max. It has the same load and hold timing as output_data.
//
// Ports
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : argmax_4_16_if.slave (score input stream, index output stream)
// ---------------------------------------------------------------------------
module argmax_4_16 #(
  parameter int M = 4,
  parameter int T = 16
) (
  input  logic         clk,
  input  logic         reset,
  argmax_4_16_if.slave bus
);
  localparam int IW = (M > 1) ? $clog2(M) : 1;

  logic        [IW-1:0] cnt;
  logic signed [T-1:0]  best_val;
  logic        [IW-1:0] best_idx;
  logic        [IW-1:0] out_reg;
  logic                 out_valid;
`ifdef ARGMAX_MAXVAL_EN
  logic        [T-1:0]  out_max;
`endif

  logic                 last;
  logic                 in_fire;
  logic                 out_fire;
  logic                 cand;
  logic signed [T-1:0]  in_s;
  logic        [IW-1:0] final_idx;
  logic signed [T-1:0]  final_val;

  assign last = (cnt == IW'(M - 1));

  // The last element stalls only while a result is still held. Every term is
  // a register, so output_ready has no combinational path to input_ready.
  assign bus.input_ready = !(last && out_valid);

  assign in_fire  = bus.input_valid && bus.input_ready;
  assign out_fire = out_valid && bus.output_ready;
  assign in_s     = $signed(bus.input_data);

  // Element 0 always seeds the scan. After that only a strictly greater score
  // replaces the best one, so ties keep the lower index. cand is only used
  // when in_fire is high, so junk data on idle cycles has no effect.
  assign cand      = (cnt == '0) || (in_s > best_val);
  assign final_idx = cand ? cnt  : best_idx;
  assign final_val = cand ? in_s : best_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      best_val  <= '0;
      best_idx  <= '0;
      out_reg   <= '0;
      out_valid <= 1'b0;
`ifdef ARGMAX_MAXVAL_EN
      out_max   <= '0;
`endif
    end else begin
      if (in_fire) begin
        best_val <= final_val;
        best_idx <= final_idx;
        if (last) begin
          cnt     <= '0;
          out_reg <= final_idx;
`ifdef ARGMAX_MAXVAL_EN
          out_max <= final_val;
`endif
        end else begin
          cnt <= cnt + IW'(1);
        end
      end
      // A load and a drain cannot fall on the same edge: a load needs
      // input_ready, which is low whenever a result is held at the last
      // element. The load still takes priority here.
      if (in_fire && last) begin
        out_valid <= 1'b1;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.output_valid = out_valid;
  assign bus.output_data  = out_reg;
`ifdef ARGMAX_MAXVAL_EN
  assign bus.output_max   = out_max;
`endif
endmodule

// File: tb/tb_argmax_4_16.sv
// ---------------------------------------------------------------------------
// tb_argmax_4_16 : self-checking bench for argmax_4_16 (M=4, T=16).
// Table of directed vectors, hand-written backpressure and reset sequences,
// and a random-handshake run checked against an expected-result queue.
// ---------------------------------------------------------------------------
module tb_argmax_4_16;
  localparam int M  = 4;
  localparam int T  = 16;
  localparam int IW = 2;

  typedef struct {
    logic [M-1:0][T-1:0] d;
    logic [IW-1:0]       idx;
    logic [T-1:0]        mx;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  logic [IW-1:0] exp_q[$];
  logic [T-1:0]  exp_max_q[$];

  argmax_4_16_if #(.T(T), .IW(IW)) bus ();

  argmax_4_16 #(.M(M), .T(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---- clock / reset ------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---- checking -----------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] golden_idx(input logic [M-1:0][T-1:0] d);
    int bi;
    bi = 0;
    for (int i = 1; i < M; i++)
      if ($signed(d[i]) > $signed(d[bi])) bi = i;
    return IW'(bi);
  endfunction

  function automatic logic [M-1:0][T-1:0] mk(input int a, input int b, input int c, input int e);
    logic [M-1:0][T-1:0] r;
    r[0] = a[T-1:0];
    r[1] = b[T-1:0];
    r[2] = c[T-1:0];
    r[3] = e[T-1:0];
    return r;
  endfunction

  // ---- driver -------------------------------------------------------------
  // Called at posedge+1. Holds one element until it is accepted and returns
  // at posedge+1 just after the accepting edge.
  task automatic push(input logic [T-1:0] v);
    int n;
    n = 0;
    bus.input_valid = 1'b1;
    bus.input_data  = v;
    while (!bus.input_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.input_ready) check("push_timeout", 32'(bus.input_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.input_valid = 1'b0;
    bus.input_data  = $urandom();
  endtask

  // ---- test body ----------------------------------------------------------
  vec_t tbl[7];

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.input_valid  = 1'b0;
    bus.input_data   = '0;
    bus.output_ready = 1'b0;
    reset = 1'b0;

    tbl[0] = '{mk(3, -7, 10, 2),          2'd2, 16'd10};
    tbl[1] = '{mk(5, 5, 5, 5),            2'd0, 16'd5};
    tbl[2] = '{mk(-1, -3, -1, -2),        2'd0, 16'hFFFF};
    tbl[3] = '{mk(-8, -4, -32768, -5),    2'd1, 16'hFFFC};
    tbl[4] = '{mk(-32768, 32767, 32767, 0), 2'd1, 16'h7FFF};
    tbl[5] = '{mk(1, 2, 3, 4),            2'd3, 16'd4};
    tbl[6] = '{mk(4, 3, 2, 1),            2'd0, 16'd4};

    do_reset();
    check("reset_ovalid", 32'(bus.output_valid), 32'd0);
    check("reset_odata",  32'(bus.output_data),  32'd0);
    check("reset_iready", 32'(bus.input_ready),  32'd1);

    // Directed table: valid and ready held high.
    bus.output_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      for (int e = 0; e < M - 1; e++) push(tbl[v].d[e]);
      check($sformatf("v%0d_pre_valid", v), 32'(bus.output_valid), 32'd0);
      push(tbl[v].d[M-1]);
      check($sformatf("v%0d_valid", v), 32'(bus.output_valid), 32'd1);
      check($sformatf("v%0d_idx", v),   32'(bus.output_data),  32'(tbl[v].idx));
`ifdef ARGMAX_MAXVAL_EN
      check($sformatf("v%0d_max", v),   32'(bus.output_max),   32'(tbl[v].mx));
`endif
      @(posedge clk);
      #1;
      check($sformatf("v%0d_drop", v), 32'(bus.output_valid), 32'd0);
    end

    // Backpressure: A={0,0,0,9} held, B={9,1,2,3} scanned under it.
    bus.output_ready = 1'b0;
    push(16'd0); push(16'd0); push(16'd0); push(16'd9);
    check("bp_a_valid", 32'(bus.output_valid), 32'd1);
    check("bp_a_idx",   32'(bus.output_data),  32'd3);
    for (int e = 0; e < 3; e++) begin
      check($sformatf("bp_b%0d_ready", e), 32'(bus.input_ready), 32'd1);
      push(e == 0 ? 16'd9 : T'(e));
    end
    bus.input_valid = 1'b1;
    bus.input_data  = 16'd3;
    for (int c = 0; c < 3; c++) begin
      check("bp_stall_ready", 32'(bus.input_ready),  32'd0);
      check("bp_stall_valid", 32'(bus.output_valid), 32'd1);
      check("bp_stall_data",  32'(bus.output_data),  32'd3);
      @(posedge clk);
      #1;
    end
    bus.output_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_a_drained", 32'(bus.output_valid), 32'd0);
    check("bp_b3_ready",  32'(bus.input_ready),  32'd1);
    @(posedge clk);
    #1;
    bus.input_valid = 1'b0;
    check("bp_b_valid", 32'(bus.output_valid), 32'd1);
    check("bp_b_idx",   32'(bus.output_data),  32'd0);
    @(posedge clk);
    #1;
    check("bp_b_drop", 32'(bus.output_valid), 32'd0);

    // Reset mid-vector with a held result: both must be discarded.
    bus.output_ready = 1'b0;
    push(16'd1); push(16'd5); push(16'd2); push(16'd0);
    push(16'd100); push(16'd200);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_valid", 32'(bus.output_valid), 32'd0);
    check("rst_mid_data",  32'(bus.output_data),  32'd0);
    reset = 1'b0;
    bus.output_ready = 1'b1;
    push(16'd1); push(16'd0); push(16'd0);
    check("rst_after_pre", 32'(bus.output_valid), 32'd0);
    push(16'd0);
    check("rst_after_valid", 32'(bus.output_valid), 32'd1);
    check("rst_after_idx",   32'(bus.output_data),  32'd0);
    @(posedge clk);
    #1;

    // Random handshakes against the expected-result queue.
    bus.output_ready = 1'b0;
    fork
      begin : drv
        int cyc;
        cyc = 0;
        for (int v = 0; v < 60; v++) begin
          logic [M-1:0][T-1:0] d;
          for (int e = 0; e < M; e++) begin
            case ($urandom_range(0, 5))
              0:       d[e] = 16'h8000;
              1:       d[e] = 16'h7FFF;
              2:       d[e] = T'($urandom_range(0, 3));
              default: d[e] = T'($urandom());
            endcase
          end
          exp_q.push_back(golden_idx(d));
          exp_max_q.push_back(d[golden_idx(d)]);
          for (int e = 0; e < M; e++) begin
            logic done;
            done = 1'b0;
            while (!done && cyc < 20000) begin
              bus.input_valid = 1'($urandom_range(0, 1));
              bus.input_data  = bus.input_valid ? d[e] : T'($urandom());
              done = bus.input_valid && bus.input_ready;
              @(posedge clk);
              #1;
              cyc++;
            end
          end
        end
        bus.input_valid = 1'b0;
      end
      begin : mon
        int got;
        int cyc;
        logic held;
        logic [IW-1:0] held_data;
        got = 0;
        cyc = 0;
        held = 1'b0;
        held_data = '0;
        while (got < 60 && cyc < 25000) begin
          bus.output_ready = 1'($urandom_range(0, 1));
          if (held) check("rnd_hold", 32'(bus.output_data), 32'(held_data));
          if (bus.output_valid && bus.output_ready) begin
            if (exp_q.size() == 0) begin
              check("rnd_unexpected", 32'(bus.output_valid), 32'd0);
            end else begin
              check("rnd_idx", 32'(bus.output_data), 32'(exp_q.pop_front()));
`ifdef ARGMAX_MAXVAL_EN
              check("rnd_max", 32'(bus.output_max), 32'(exp_max_q.pop_front()));
`else
              void'(exp_max_q.pop_front());
`endif
            end
            got++;
          end
          held      = bus.output_valid && !bus.output_ready;
          held_data = bus.output_data;
          @(posedge clk);
          #1;
          cyc++;
        end
        check("rnd_count", 32'(got), 32'd60);
        bus.output_ready = 1'b0;
      end
    join

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
